// File: rtl/q01d.sv
// rtl/q01d.sv - registered evaluator for s = (b|c)&(a|~b|~c)&(~a|~b|d)
// Normal mode samples a/b/c/d; sweep mode walks all 16 minterms into a truth table.
module q01d (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  output logic        s,
  output logic        out_valid,
  input  logic        sweep_start,
  output logic        sweep_busy,
  output logic        sweep_done,
  output logic [15:0] tt,
  output logic [4:0]  ones_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] idx;
  logic [3:0] eval_idx;
  logic       eval_f;

  // One evaluator shared by both modes: the sweep index replaces the pins while running.
  assign eval_idx = (state == RUN) ? idx : {a, b, c, d};
  assign eval_f   = (eval_idx[2] | eval_idx[1])
                  & (eval_idx[3] | ~eval_idx[2] | ~eval_idx[1])
                  & (~eval_idx[3] | ~eval_idx[2] | eval_idx[0]);

  assign sweep_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sweep_start) state_nxt = RUN;
      RUN:     if (idx == 4'd15) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s          <= 1'b0;
      out_valid  <= 1'b0;
      sweep_done <= 1'b0;
      tt         <= 16'h0000;
      ones_cnt   <= 5'd0;
      idx        <= 4'd0;
    end else begin
      out_valid  <= 1'b0;
      sweep_done <= (state == DONE);
      case (state)
        IDLE: begin
          // sweep_start has priority; a coincident in_valid sample is dropped
          if (sweep_start) begin
            idx      <= 4'd0;
            tt       <= 16'h0000;
            ones_cnt <= 5'd0;
          end else if (in_valid) begin
            s         <= eval_f;
            out_valid <= 1'b1;
          end
        end
        RUN: begin
          s         <= eval_f;
          out_valid <= 1'b1;
          tt[idx]   <= eval_f;
          ones_cnt  <= ones_cnt + {4'd0, eval_f};
          idx       <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_q01d.sv
// tb/tb_q01d.sv - table, sweep-sequence and randomized checks for q01d
// Reference is the minterm list of the function, independent of the gate expression.
module tb_q01d;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic        s, out_valid;
  logic        sweep_start = 1'b0;
  logic        sweep_busy, sweep_done;
  logic [15:0] tt;
  logic [4:0]  ones_cnt;

  int total = 0;
  int bad   = 0;

  q01d dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .d(d),
    .s(s), .out_valid(out_valid),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .tt(tt), .ones_cnt(ones_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] in;
    logic       exp_s;
  } vec_t;

  vec_t        vecs[16];
  logic [15:0] ref_tt;
  int          ref_ones;

  function automatic logic ref_f(input int i);
    return (i == 2 || i == 3 || i == 4 || i == 5 || i == 10 || i == 11 || i == 13 || i == 15);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] x);
    in_valid = v;
    {a, b, c, d} = x;
  endtask

  // Runs one sweep; arb puts in_valid(0011) beside the start, lock pokes inputs during RUN.
  task automatic run_sweep(input bit arb, input bit lock);
    int done_seen;
    sweep_start = 1'b1;
    if (arb) drive(1'b1, 4'b0011);
    else     drive(1'b0, 4'b0000);
    step();                                  // edge 0
    sweep_start = 1'b0;
    drive(1'b0, 4'b0000);
    chk("sweep_busy_after_start", sweep_busy, 1);
    chk("arb_no_out_valid", out_valid, 0);
    for (int k = 1; k <= 16; k++) begin
      if (lock && k >= 3 && k <= 10) begin
        sweep_start = 1'b1;
        drive(1'b1, 4'b0110);
      end else begin
        sweep_start = 1'b0;
        drive(1'b0, 4'b0000);
      end
      step();                                // edge k evaluates idx k-1
      chk($sformatf("run_valid_%0d", k - 1), out_valid, 1);
      chk($sformatf("run_s_%0d", k - 1), s, ref_f(k - 1));
      chk($sformatf("run_busy_%0d", k), sweep_busy, 1);
      chk($sformatf("run_no_done_%0d", k), sweep_done, 0);
    end
    sweep_start = 1'b0;
    drive(1'b0, 4'b0000);
    chk("tt_final", tt, ref_tt);
    chk("ones_final", ones_cnt, ref_ones);
    done_seen = 0;
    for (int k = 0; k < 4; k++) begin
      step();                                // edge 17 onward
      if (k == 0) begin
        chk("done_pulse", sweep_done, 1);
        chk("busy_low_at_done", sweep_busy, 0);
        chk("out_valid_low_after_run", out_valid, 0);
      end
      done_seen += int'(sweep_done);
    end
    chk("done_single_pulse", done_seen, 1);
    chk("tt_hold", tt, ref_tt);
    chk("ones_hold", ones_cnt, ref_ones);
  endtask

  initial begin
    logic exp_s;
    logic exp_v;
    logic [3:0] rx;
    logic rv;

    ref_tt = '0;
    ref_ones = 0;
    for (int i = 0; i < 16; i++) begin
      ref_tt[i] = ref_f(i);
      ref_ones += int'(ref_f(i));
      vecs[i].in    = 4'(i);
      vecs[i].exp_s = ref_f(i);
    end

    // reset state
    #12;
    chk("rst_s", s, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", sweep_busy, 0);
    chk("rst_done", sweep_done, 0);
    chk("rst_tt", tt, 0);
    chk("rst_ones", ones_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // exhaustive normal mode, back-to-back
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, vecs[i].in);
      step();
      chk($sformatf("norm_s_%0d", i), s, vecs[i].exp_s);
      chk($sformatf("norm_valid_%0d", i), out_valid, 1);
    end
    drive(1'b0, 4'b0000);
    step();
    chk("norm_valid_drop", out_valid, 0);
    chk("norm_s_hold", s, vecs[15].exp_s);

    run_sweep(1'b0, 1'b0);
    run_sweep(1'b1, 1'b0);
    run_sweep(1'b0, 1'b1);

    // reset mid-sweep once idx reaches 7
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    for (int k = 0; k < 7; k++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_s", s, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", sweep_busy, 0);
    chk("mid_rst_done", sweep_done, 0);
    chk("mid_rst_tt", tt, 0);
    chk("mid_rst_ones", ones_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int stray = 0;
      for (int k = 0; k < 20; k++) begin
        step();
        stray += int'(sweep_done) + int'(sweep_busy);
      end
      chk("no_done_after_abort", stray, 0);
    end
    run_sweep(1'b0, 1'b0);

    // randomized normal-mode traffic against the minterm model
    exp_s = s;
    for (int n = 0; n < 300; n++) begin
      rv = 1'($urandom_range(0, 1));
      rx = 4'($urandom_range(0, 15));
      drive(rv, rx);
      if (rv) exp_s = ref_f(int'(rx));
      exp_v = rv;
      step();
      chk("rand_valid", out_valid, exp_v);
      chk("rand_s", s, exp_s);
    end
    drive(1'b0, 4'b0000);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
